// File: rtl/uart_imem_loader.sv
// uart_imem_loader
//
// Receives a program image over the UART RX pin (8N1, LSB first, idle high)
// and writes it word by word into the instruction RAM. Four consecutive
// accepted bytes form one little-endian word: the first byte lands in
// bits [7:0] and the fourth in bits [31:24]. The loader is only active while
// load_imem is high. A rising edge of load_imem starts a new image at word 0.
//
// Ports:
//   clk, reset     system clock (rising edge), synchronous active-high reset
//   load_imem      loader enable; a rising edge restarts the image
//   uart_port_rxd  asynchronous UART RX line
//   imem_wr        one-cycle instruction RAM write strobe
//   imem_addr      word address for the write (wraps)
//   imem_wdata     assembled little-endian word
//   word_cnt       words written since the last load_imem rise (saturating)
//   frame_err      sticky: a stop bit was sampled low
//   busy           RX FSM not in IDLE
//
// Handshake: there is no back-pressure. The RAM must accept imem_wr in the
// cycle it is high. imem_addr and imem_wdata are stable during that cycle.
module uart_imem_loader #(
  parameter int CLKS_PER_BIT    = 868,
  parameter int IMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       load_imem,
  input  logic                       uart_port_rxd,
  output logic                       imem_wr,
  output logic [IMEM_ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]                imem_wdata,
  output logic [IMEM_ADDR_WIDTH:0]   word_cnt,
  output logic                       frame_err,
  output logic                       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_IDLE
  } rx_state_t;

  rx_state_t         state;
  rx_state_t         next_state;
  logic              rxd_meta;
  logic              rxd_s;
  logic              load_q;
  logic [CNT_W-1:0]  baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        rx_byte;
  logic [1:0]        byte_idx;
  logic              half_done;
  logic              bit_done;
  logic              load_rise;
  logic              byte_ok;
  logic              stop_bad;

  assign busy = (state != S_IDLE);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic and per-cycle event decode
  always_comb begin
    next_state = state;
    half_done  = (baud_cnt == HALF_LAST);
    bit_done   = (baud_cnt == BIT_LAST);
    load_rise  = load_imem && !load_q;
    byte_ok    = load_imem && (state == S_STOP) && bit_done && rxd_s;
    stop_bad   = load_imem && (state == S_STOP) && bit_done && !rxd_s;
    case (state)
      S_IDLE:      if (!rxd_s) next_state = S_START;
      // Re-check the start bit in its middle to reject short glitches.
      S_START:     if (half_done) next_state = rxd_s ? S_IDLE : S_DATA;
      S_DATA:      if (bit_done && bit_idx == 3'd7) next_state = S_STOP;
      // Leaving at mid-stop gives half a bit of margin for the next start.
      S_STOP:      if (bit_done) next_state = rxd_s ? S_IDLE : S_WAIT_IDLE;
      // A break (line held low) must not look like a stream of zero bytes.
      S_WAIT_IDLE: if (rxd_s) next_state = S_IDLE;
      default:     next_state = S_IDLE;
    endcase
    if (!load_imem) next_state = S_IDLE;
  end

  // Input synchronizer, bit timing and byte shift register
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_meta <= 1'b1;
      rxd_s    <= 1'b1;
      load_q   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      rx_byte  <= '0;
    end else begin
      rxd_meta <= uart_port_rxd;
      rxd_s    <= rxd_meta;
      load_q   <= load_imem;
      case (state)
        S_START:        baud_cnt <= half_done ? '0 : baud_cnt + 1'b1;
        S_DATA, S_STOP: baud_cnt <= bit_done  ? '0 : baud_cnt + 1'b1;
        default:        baud_cnt <= '0;
      endcase
      if (!load_imem) baud_cnt <= '0;
      if (state == S_START && half_done) bit_idx <= '0;
      if (state == S_DATA && bit_done) begin
        rx_byte <= {rxd_s, rx_byte[7:1]};
        bit_idx <= bit_idx + 1'b1;
      end
    end
  end

  // Word assembly, write strobe and status
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_wr    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      word_cnt   <= '0;
      frame_err  <= 1'b0;
      byte_idx   <= '0;
    end else begin
      imem_wr <= 1'b0;
      // The address advances in the cycle after the strobe, so it holds
      // steady for the whole write cycle.
      if (imem_wr) imem_addr <= imem_addr + 1'b1;
      if (!load_imem) byte_idx <= '0;
      if (load_rise) begin
        imem_addr <= '0;
        byte_idx  <= '0;
        word_cnt  <= '0;
        frame_err <= 1'b0;
      end else begin
        if (stop_bad) frame_err <= 1'b1;
        if (byte_ok) begin
          imem_wdata[8*byte_idx +: 8] <= rx_byte;
          byte_idx                    <= byte_idx + 1'b1;
          if (byte_idx == 2'd3) begin
            imem_wr <= 1'b1;
            if (word_cnt != '1) word_cnt <= word_cnt + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Testbench for uart_imem_loader with CLKS_PER_BIT=16.
// Two instances share every input: dut (10-bit address) and dut_w2 (2-bit
// address, used for the wrap and saturation case). Writes from dut are
// checked against an expected queue of {addr, data}.
module tb_uart_imem_loader;

  localparam int CPB = 16;
  localparam int W   = 42;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  logic load_imem;
  logic rxd;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        imem_wr;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic [10:0] word_cnt;
  logic        frame_err;
  logic        busy;

  logic        imem_wr_2;
  logic [1:0]  imem_addr_2;
  logic [31:0] imem_wdata_2;
  logic [2:0]  word_cnt_2;
  logic        frame_err_2;
  logic        busy_2;

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .IMEM_ADDR_WIDTH(10)) dut (
    .clk(clk), .reset(reset), .load_imem(load_imem), .uart_port_rxd(rxd),
    .imem_wr(imem_wr), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .word_cnt(word_cnt), .frame_err(frame_err), .busy(busy)
  );

  uart_imem_loader #(.CLKS_PER_BIT(CPB), .IMEM_ADDR_WIDTH(2)) dut_w2 (
    .clk(clk), .reset(reset), .load_imem(load_imem), .uart_port_rxd(rxd),
    .imem_wr(imem_wr_2), .imem_addr(imem_addr_2), .imem_wdata(imem_wdata_2),
    .word_cnt(word_cnt_2), .frame_err(frame_err_2), .busy(busy_2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];
  logic [33:0]  obs2_q[$];
  int   last_wr_cyc = -1000;
  int   frame_start = 0;
  logic busy_seen   = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [W-1:0] mon_e;
  always @(negedge clk) begin
    if (!reset && imem_wr) begin
      last_wr_cyc = cyc;
      check("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(imem_addr), 64'(mon_e[41:32]));
        check("wr_data", 64'(imem_wdata), 64'(mon_e[31:0]));
      end
    end
    if (busy) busy_seen = 1'b1;
    if (!reset && imem_wr_2) obs2_q.push_back({imem_addr_2, imem_wdata_2});
  end

  // ---------------- driver tasks ----------------
  // One 8N1 frame, 10 bit times; all driving happens on negedges.
  task automatic send_byte(input logic [7:0] b, input logic stop_val);
    frame_start = cyc;
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = stop_val;
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic restart_load();
    load_imem = 1'b0;
    repeat (3) @(negedge clk);
    load_imem = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0]  b;
  logic [31:0] word;
  initial begin
    reset = 1'b1;
    load_imem = 1'b0;
    rxd = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // 1: reset values, then traffic with the loader disabled
    check("rst_wr", 64'(imem_wr), 64'd0);
    check("rst_addr", 64'(imem_addr), 64'd0);
    check("rst_wdata", 64'(imem_wdata), 64'd0);
    check("rst_cnt", 64'(word_cnt), 64'd0);
    check("rst_ferr", 64'(frame_err), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    busy_seen = 1'b0;
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    idle_bits(1);
    check("off_busy_seen", 64'(busy_seen), 64'd0);

    // 2: single word. Start bit driven at cycle 0: two sync flops plus the
    // IDLE detect put START at cycle 3, mid-start at 11, bit0 at 27, stop
    // sample at 27+8*16=155; the strobe is visible in cycle 155.
    load_imem = 1'b1;
    repeat (3) @(negedge clk);
    exp_q.push_back({10'd0, 32'h0010_0513});
    send_byte(8'h13, 1'b1);
    send_byte(8'h05, 1'b1);
    send_byte(8'h10, 1'b1);
    send_byte(8'h00, 1'b1);
    check("t2_wr_latency", 64'(last_wr_cyc - frame_start), 64'd155);
    check("t2_cnt", 64'(word_cnt), 64'd1);
    check("t2_q_empty", 64'(exp_q.size()), 64'd0);

    // 3: eight back-to-back bytes
    restart_load();
    exp_q.push_back({10'd0, 32'h0403_0201});
    exp_q.push_back({10'd1, 32'h0807_0605});
    for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b1);
    check("t3_cnt", 64'(word_cnt), 64'd2);
    check("t3_ferr", 64'(frame_err), 64'd0);
    check("t3_q_empty", 64'(exp_q.size()), 64'd0);

    // 4: second byte has a low stop bit and is dropped
    restart_load();
    exp_q.push_back({10'd0, 32'h3322_11AA});
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b0);
    idle_bits(2);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check("t4_ferr", 64'(frame_err), 64'd1);
    check("t4_cnt", 64'(word_cnt), 64'd1);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);
    restart_load();
    check("t4_ferr_clr", 64'(frame_err), 64'd0);
    check("t4_cnt_clr", 64'(word_cnt), 64'd0);

    // 5: start glitch, then partial word abandoned by dropping load_imem
    busy_seen = 1'b0;
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    rxd = 1'b1;
    repeat (40) @(negedge clk);
    check("t5_glitch_busy_seen", 64'(busy_seen), 64'd1);
    check("t5_glitch_busy", 64'(busy), 64'd0);
    check("t5_glitch_cnt", 64'(word_cnt), 64'd0);
    send_byte(8'hDE, 1'b1);
    send_byte(8'hAD, 1'b1);
    restart_load();
    exp_q.push_back({10'd0, 32'h1234_5678});
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    check("t5_cnt", 64'(word_cnt), 64'd1);
    check("t5_q_empty", 64'(exp_q.size()), 64'd0);

    // 6: address wrap and count saturation on the 2-bit instance
    restart_load();
    obs2_q.delete();
    for (int w = 0; w < 8; w++) begin
      for (int j = 0; j < 4; j++) word[8*j +: 8] = 8'(8'h40 + 4*w + j);
      exp_q.push_back({10'(w), word});
      for (int j = 0; j < 4; j++) begin
        b = 8'(8'h40 + 4*w + j);
        send_byte(b, 1'b1);
      end
      if (w == 4) check("t6_cnt2_at5", 64'(word_cnt_2), 64'd5);
    end
    check("t6_cnt2_sat", 64'(word_cnt_2), 64'd7);
    check("t6_cnt", 64'(word_cnt), 64'd8);
    check("t6_q_empty", 64'(exp_q.size()), 64'd0);
    check("t6_w2_writes", 64'(obs2_q.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < obs2_q.size()) begin
        for (int j = 0; j < 4; j++) word[8*j +: 8] = 8'(8'h40 + 4*i + j);
        check("t6_w2_addr", 64'(obs2_q[i][33:32]), 64'(i % 4));
        check("t6_w2_data", 64'(obs2_q[i][31:0]), 64'(word));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_imem_loader.md
Name: uart_imem_loader

Overview:
- UART-side instruction-memory loader: receives a program image over the SoC UART RX pin and writes it, word by word, into the instruction RAM.
- Sits between the board-level uart_port_rxd pin and the soc_imem_inst write port; active only while load_imem is high.
- Byte packing is little-endian: the first received byte is bits [7:0], the fourth is bits [31:24]. This is the same packing as the simulation backdoor image load.
- Serial format: 8N1, LSB first, idle high.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit; minimum 8 (868 = 100 MHz / 115200).
- IMEM_ADDR_WIDTH, 10: word-address width of the instruction RAM.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- load_imem  input  1  loader enable; a rising edge starts a new image.
- uart_port_rxd  input  1  asynchronous UART RX line, idle high.
- imem_wr  output  1  one-cycle instruction RAM write strobe.
- imem_addr  output  IMEM_ADDR_WIDTH  word address for the write.
- imem_wdata  output  32  assembled little-endian word.
- word_cnt  output  IMEM_ADDR_WIDTH+1  words written since the last load_imem rising edge; saturates at all-ones.
- frame_err  output  1  sticky flag: a stop bit was sampled low.
- busy  output  1  high while the RX FSM is not in IDLE.

Behaviour:
- Reset values (synchronous, active-high, applied on clk rising edge):
  - imem_wr=0, imem_addr=0, imem_wdata=0, word_cnt=0, frame_err=0, busy=0.
  - FSM=IDLE, byte index=0, bit and baud counters=0, synchronizer flops=1.
  - Reset asserted mid-frame aborts the frame; no write is issued.
- Input synchronizer: uart_port_rxd passes through a 2-flop synchronizer; rxd_s is the synchronized signal and is the only value the FSM uses.
- RX FSM (held in IDLE while load_imem=0):
  - IDLE: rxd_s=0 -> START, baud counter=0.
  - START: after CLKS_PER_BIT/2 cycles (integer division), re-sample. rxd_s=0 -> DATA, bit index=0. rxd_s=1 -> IDLE (glitch rejected).
  - DATA: sample rxd_s every CLKS_PER_BIT cycles into bit[index], LSB first. After bit 7 -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - rxd_s=1: byte accepted -> IDLE.
    - rxd_s=0: frame_err<=1, byte discarded -> WAIT_IDLE.
  - WAIT_IDLE: stay until rxd_s=1, then -> IDLE. A line held at break does not generate bytes.
- Word assembly:
  - On an accepted byte, imem_wdata[8*idx +: 8] <= byte, then idx increments (2-bit, wraps).
  - When the accepted byte has idx==3:
    - imem_wr=1 exactly one clock after the stop-bit sample clock, for one cycle.
    - imem_addr holds the current word address during that cycle.
    - The word address increments on the cycle after the strobe and wraps modulo 2^IMEM_ADDR_WIDTH.
    - word_cnt increments (saturating).
  - imem_addr and imem_wdata are stable whenever imem_wr=1.
- load_imem control:
  - Rising edge (registered previous value 0, current value 1) clears the word address, idx, word_cnt and frame_err in that cycle.
  - load_imem=0 forces the FSM to IDLE and discards the partial word and any in-flight byte; no write is issued.
  - word_cnt and frame_err hold their values while load_imem=0.
  - A byte whose stop sample and load_imem fall occur in the same cycle is discarded.
- Simultaneous events: reset has priority over load_imem; the load_imem rising-edge clear has priority over byte acceptance.
- Back-to-back frames: a start bit arriving immediately after the stop bit is received correctly. IDLE is re-entered at mid-stop, leaving half a bit of margin.

Test Plan (bench uses CLKS_PER_BIT=16, IMEM_ADDR_WIDTH=10 unless stated):
1. Hold reset 3 cycles with rxd=1 -> all outputs 0, busy=0. Drive bytes with load_imem=0 -> no imem_wr, busy stays 0.
2. Raise load_imem, send 0x13,0x05,0x10,0x00 -> single imem_wr pulse with addr=0, wdata=0x00100513, one clk after the 4th stop-bit sample; word_cnt=1.
3. Send 8 bytes back-to-back (no idle gap) -> writes at addr 0 then addr 1; word_cnt=2; frame_err=0.
4. Byte 2 sent with stop bit 0, then 4 good bytes -> frame_err=1. The first write contains the good bytes only, with the corrupted byte skipped. frame_err clears on the next load_imem rising edge.
5. Pull rxd low for 4 clks, then back to 1 -> no byte, busy returns 0. Drop load_imem after 2 bytes, re-raise it, send 4 bytes -> exactly one write, at addr 0, with the new data only.
6. IMEM_ADDR_WIDTH=2: send 5 words -> writes at addr 0,1,2,3,0; word_cnt=5 (7 saturates at 7 with width 3).
